packet_fifo: RTL
================

Name: packet_fifo

Overview:
Receiving end of the 32-bit result stream (valid/sop/eop/data) produced by the phase-extraction pipeline.
- Buffers whole packets in on-chip RAM and releases only complete, committed packets to a downstream reader over a ready/valid interface.
- The sink side has no backpressure. A packet that does not fit, or that is malformed, is dropped as a whole and counted.

Parameters:
WIDTH, 32, data word width
DEPTH_LOG2, 9, log2 of buffer depth in words (512 words)
CNT_WIDTH, 16, width of the packet and drop statistics counters

Ports:
clk  input  1  main clock (single clock domain)
reset  input  1  synchronous, active-high reset
sink_valid  input  1  input word valid
sink_sop  input  1  first word of packet
sink_eop  input  1  last word of packet
sink_data  input  WIDTH  input word
source_ready  input  1  reader accepts the current word
source_valid  output  1  output word valid
source_sop  output  1  first word of packet
source_eop  output  1  last word of packet
source_data  output  WIDTH  output word
pkt_count  output  CNT_WIDTH  packets committed since reset, saturating
drop_count  output  CNT_WIDTH  packets dropped since reset, saturating
full  output  1  no free word; level

Behaviour:
- Reset: synchronous, active-high, on clk. It clears all pointers, counters, the output register and the receive state. All outputs are 0 in the cycle after reset is sampled high. A partially received packet is discarded and not counted as dropped. RAM contents are don't-care.
- Storage: each RAM entry holds {sop, eop, data}, WIDTH+2 bits.
- Pointers: DEPTH_LOG2+1 bits, so wrap-around is detected by the MSB.
  - wr_ptr: tentative write pointer.
  - commit_ptr: end of the last complete packet.
  - rd_ptr: read pointer.
  - used = wr_ptr - rd_ptr; full when used == 2^DEPTH_LOG2.
- Receive FSM has three states: IDLE, RECV, DISCARD.
  - IDLE + valid&sop: write the word.
    - If eop is also set: commit (single-word packet), stay IDLE.
    - Else go to RECV.
  - IDLE + valid&!sop: ignore the word, drop_count++, go to DISCARD.
  - RECV + valid&!sop: write the word. On eop, commit and go to IDLE.
  - RECV + valid&sop: abort the current packet (wr_ptr <= commit_ptr), drop_count++. Treat the word as the new packet's first word, written at commit_ptr. Stay RECV, or commit if eop is also set.
  - DISCARD: ignore words until valid&eop, then go to IDLE. A valid&sop seen while in DISCARD starts a new packet as in IDLE.
- Commit: commit_ptr <= write address + 1 in the same cycle as the eop write; pkt_count++.
- Overflow: valid arrives while full in IDLE or RECV:
  - wr_ptr <= commit_ptr, drop_count++.
  - Go to DISCARD, or to IDLE if the word carries eop.
  - The word is not written.
  - Committed data is never overwritten.
- Counters saturate at 2^CNT_WIDTH-1.
- Read side:
  - Output is a registered stage fed by a synchronous RAM read with prefetch.
  - Only entries below commit_ptr are visible.
  - Transfer occurs when source_valid & source_ready.
  - source_valid and the payload stay stable until the word is accepted.
  - Sustains 1 word/cycle while source_ready stays high.
- Latency: with the buffer empty, commit of eop at cycle N gives source_valid = 1 (with the first word of that packet) at N+2.
- Simultaneous read and write: allowed every cycle. A read frees its slot for a write in the next cycle, not the same cycle.
- full is computed from wr_ptr, so it is asserted even while uncommitted words occupy the space.

Decomposition:
- Shared package pr3_pkg:
  - pkt_state_t enum (IDLE, RECV, DISCARD).
  - Constant RESULT_WIDTH = 32.
  - Typedef fifo_word_t = struct {sop, eop, data}.
- One sub-module, sdp_ram: simple dual-port synchronous RAM, one write port and one read port, registered read, parameterised width and depth.

Test Plan (bench uses DEPTH_LOG2=4, i.e. 16 words):
- 4-word packet (data 0x11..0x14, sop on the first word, eop on the last), source_ready=1 -> source_valid rises 2 cycles after the eop cycle; words 0x11..0x14 leave on consecutive cycles with sop/eop on the first/last; pkt_count=1, drop_count=0.
- 3-word packet, then sop arriving mid-packet at word 2 of a second packet, then 2-word packet, source_ready=1 -> output is the 3-word packet followed by the 2-word packet only; pkt_count=2, drop_count=1.
- source_ready=0, send 12-word packet then 6-word packet -> full asserts during the second packet; the second packet is dropped with drop_count=1; after source_ready=1 exactly 12 words are output; full deasserts.
- Words without a leading sop (0xAA, 0xBB with eop), then a valid 1-word packet sop+eop 0xCC -> only 0xCC is output, with sop=eop=1; drop_count=1.
- Toggle source_ready every cycle during a 5-word packet -> every word is output once, in order; data holds stable while source_ready=0.
- Assert reset for 1 cycle during word 3 of a 6-word packet with 2 committed packets still unread -> the cycle after reset, source_valid=0 and pkt_count=drop_count=0; a following 2-word packet is output intact.

Source files
------------

// File: rtl/pr3_pkg.sv
// Shared types for the phase-extraction result path: stream word layout and
// packet receive states.
package pr3_pkg;

    localparam int RESULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } pkt_state_t;

    typedef struct packed {
        logic                    sop;
        logic                    eop;
        logic [RESULT_WIDTH-1:0] data;
    } fifo_word_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// The read register holds its value while i_re is low.
module sdp_ram #(
    parameter int WIDTH      = 34,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
    logic [WIDTH-1:0] r_rdata;

    // Write port.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Registered read port; holds the last word read until the next enable.
    always_ff @(posedge clk) begin
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/packet_fifo.sv
// Packet store-and-forward buffer for the result stream. Words are written
// tentatively and become visible to the reader only once their packet's eop
// has been written. Malformed or overflowing packets are dropped whole.
//
// state   | meaning
// IDLE    | between packets, waiting for sop
// RECV    | inside a packet, words written above commit_ptr
// DISCARD | dropping words until eop (or a fresh sop)
module packet_fifo
    import pr3_pkg::*;
#(
    parameter int WIDTH      = RESULT_WIDTH,
    parameter int DEPTH_LOG2 = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sink_valid,
    input  logic                 sink_sop,
    input  logic                 sink_eop,
    input  logic [WIDTH-1:0]     sink_data,
    input  logic                 source_ready,
    output logic                 source_valid,
    output logic                 source_sop,
    output logic                 source_eop,
    output logic [WIDTH-1:0]     source_data,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic                 full
);

    localparam int                   PW          = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0]        PTR_ONE     = PW'(1);
    localparam logic [PW-1:0]        DEPTH_WORDS = PTR_ONE << DEPTH_LOG2;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    pkt_state_t           r_state;
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_commit_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [PW-1:0]        r_raddr;
    logic                 r_src_valid;
    logic [CNT_WIDTH-1:0] r_pkt_count;
    logic [CNT_WIDTH-1:0] r_drop_count;

    pkt_state_t      w_state_nxt;
    logic [PW-1:0]   w_wr_nxt;
    logic [PW-1:0]   w_commit_nxt;
    logic            w_we;
    logic            w_pkt_inc;
    logic            w_drop_inc;
    logic            w_full;
    logic            w_overflow;
    logic [DEPTH_LOG2-1:0] w_waddr;
    logic            w_avail;
    logic            w_take;
    logic            w_re;
    logic [WIDTH+1:0] w_rdata;

    // rd_ptr only moves on accepted words, so the word parked in the output
    // register still occupies its slot until the reader takes it.
    assign w_full     = (r_wr_ptr - r_rd_ptr) == DEPTH_WORDS;
    assign w_overflow = w_full && (r_state == RECV || sink_sop);
    // A sop word always restarts at commit_ptr, which also aborts a packet in flight.
    assign w_waddr    = sink_sop ? r_commit_ptr[DEPTH_LOG2-1:0] : r_wr_ptr[DEPTH_LOG2-1:0];

    // Receive FSM next-state, pointer and counter-increment decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_nxt     = r_wr_ptr;
        w_commit_nxt = r_commit_ptr;
        w_we         = 1'b0;
        w_pkt_inc    = 1'b0;
        w_drop_inc   = 1'b0;
        if (sink_valid) begin
            if (w_overflow) begin
                w_drop_inc  = 1'b1;
                w_wr_nxt    = r_commit_ptr;
                w_state_nxt = sink_eop ? IDLE : DISCARD;
            end else if (sink_sop) begin
                w_we       = 1'b1;
                w_wr_nxt   = r_commit_ptr + PTR_ONE;
                w_drop_inc = (r_state == RECV);
                if (sink_eop) begin
                    w_commit_nxt = r_commit_ptr + PTR_ONE;
                    w_pkt_inc    = 1'b1;
                    w_state_nxt  = IDLE;
                end else begin
                    w_state_nxt = RECV;
                end
            end else if (r_state == RECV) begin
                w_we     = 1'b1;
                w_wr_nxt = r_wr_ptr + PTR_ONE;
                if (sink_eop) begin
                    w_commit_nxt = r_wr_ptr + PTR_ONE;
                    w_pkt_inc    = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end else if (r_state == IDLE) begin
                w_drop_inc  = 1'b1;
                w_state_nxt = DISCARD;
            end else if (sink_eop) begin
                w_state_nxt = IDLE;
            end
        end
    end

    // Receive state, write/commit pointers and saturating statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_pkt_count  <= '0;
            r_drop_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_nxt;
            r_commit_ptr <= w_commit_nxt;
            if (w_pkt_inc && r_pkt_count != '1)
                r_pkt_count <= r_pkt_count + CNT_ONE;
            if (w_drop_inc && r_drop_count != '1)
                r_drop_count <= r_drop_count + CNT_ONE;
        end
    end

    // The RAM read register doubles as the output stage: a new read is issued
    // only when that stage is empty or being emptied, otherwise it holds.
    assign w_avail = (r_raddr != r_commit_ptr);
    assign w_take  = r_src_valid && source_ready;
    assign w_re    = w_avail && (!r_src_valid || source_ready);

    // Read-side pointers and output-stage valid flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_raddr     <= '0;
            r_rd_ptr    <= '0;
            r_src_valid <= 1'b0;
        end else begin
            if (w_re)   r_raddr  <= r_raddr + PTR_ONE;
            if (w_take) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_src_valid <= w_re || (r_src_valid && !source_ready);
        end
    end

    sdp_ram #(
        .WIDTH      (WIDTH + 2),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata ({sink_sop, sink_eop, sink_data}),
        .i_re    (w_re),
        .i_raddr (r_raddr[DEPTH_LOG2-1:0]),
        .o_rdata (w_rdata)
    );

    // RAM contents are undefined after reset, so the payload is masked by valid.
    assign source_valid = r_src_valid;
    assign source_sop   = r_src_valid & w_rdata[WIDTH+1];
    assign source_eop   = r_src_valid & w_rdata[WIDTH];
    assign source_data  = r_src_valid ? w_rdata[WIDTH-1:0] : '0;
    assign pkt_count    = r_pkt_count;
    assign drop_count   = r_drop_count;
    assign full         = w_full;

endmodule
